// File: rtl/icb_copy_pkg.sv
// icb_copy_pkg
//   Shared types and constants for the ICB copy master.
//   - state_e  : copy-engine state encoding
//   - STATE_W  : width of the state register
//   - byte_inc : byte step between consecutive data words (DW/8)
//   - addr_lsb : number of always-zero low address bits (log2(DW/8))
package icb_copy_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RD_CMD = 3'd1,
    ST_RD_RSP = 3'd2,
    ST_WR_CMD = 3'd3,
    ST_WR_RSP = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic int unsigned byte_inc(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/icb_copy_addr_gen.sv
// icb_copy_addr_gen
//   Source/destination pointer pair for the copy engine.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     load_i            capture src_i/dst_i (low word-offset bits forced to 0)
//     adv_i             advance both pointers by one data word (DW/8 bytes)
//     src_i, dst_i      start addresses to load
//     src_o, dst_o      current pointers; wrap modulo 2^AW
module icb_copy_addr_gen
  import icb_copy_pkg::*;
#(
  parameter int AW = 19,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  output logic [AW-1:0] src_o,
  output logic [AW-1:0] dst_o
);

  localparam logic [AW-1:0] INC        = AW'(byte_inc(DW));
  // Clearing the word-offset bits keeps every issued address word aligned
  localparam logic [AW-1:0] ALIGN_MASK = ~(INC - AW'(1));

  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    if (load_i) begin
      src_d = src_i & ALIGN_MASK;
      dst_d = dst_i & ALIGN_MASK;
    end else if (adv_i) begin
      // Plain AW-bit addition gives the modulo-2^AW wrap for free
      src_d = src_q + INC;
      dst_d = dst_q + INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
    end
  end

  assign src_o = src_q;
  assign dst_o = dst_q;

endmodule

// File: rtl/icb_copy_master.sv
// icb_copy_master
//   Word-by-word memory copy engine on an ICB initiator port. Each word is a
//   read command, its response, a write command and its response; only one
//   transaction is ever outstanding.
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     start, src_addr, dst_addr,  job request and parameters, sampled in IDLE only
//     len
//     busy                        high while a job is in progress
//     done                        one-cycle pulse at job end (normal or aborted)
//     err                         sticky response-error flag, cleared by next start
//     o_icb_cmd_*                 ICB command channel (valid/ready/read/addr/wdata/wmask)
//     o_icb_rsp_*                 ICB response channel (valid/ready/rdata[/err])
//   Build option:
//     ICB_COPY_ERR_EN  adds o_icb_rsp_err; an erroring response sets err and
//                      ends the job. Without it err is constant 0.
module icb_copy_master
  import icb_copy_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 19,
  parameter int MW    = DW / 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    src_addr,
  input  logic [AW-1:0]    dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             o_icb_cmd_valid,
  input  logic             o_icb_cmd_ready,
  output logic             o_icb_cmd_read,
  output logic [AW-1:0]    o_icb_cmd_addr,
  output logic [DW-1:0]    o_icb_cmd_wdata,
  output logic [MW-1:0]    o_icb_cmd_wmask,
  input  logic             o_icb_rsp_valid,
  output logic             o_icb_rsp_ready,
  input  logic [DW-1:0]    o_icb_rsp_rdata
`ifdef ICB_COPY_ERR_EN
  ,
  input  logic             o_icb_rsp_err
`endif
);

  state_e           state_q;
  logic [LEN_W-1:0] remain_q;
  logic [DW-1:0]    data_q;
  logic             cmd_valid_q;
  logic             cmd_read_q;
  logic             rsp_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             cmd_hs;
  logic             rsp_hs;
  logic             rsp_err_w;
  logic             ptr_load;
  logic             ptr_adv;
  logic [AW-1:0]    src_ptr;
  logic [AW-1:0]    dst_ptr;

`ifdef ICB_COPY_ERR_EN
  assign rsp_err_w = o_icb_rsp_err;
`else
  assign rsp_err_w = 1'b0;
`endif

  assign cmd_hs   = cmd_valid_q & o_icb_cmd_ready;
  assign rsp_hs   = rsp_ready_q & o_icb_rsp_valid;
  assign ptr_load = (state_q == ST_IDLE) & start;
  // Pointers only move on a completed write, so they are frozen while a
  // command is being offered and the address stays stable until accepted.
  assign ptr_adv  = (state_q == ST_WR_RSP) & rsp_hs;

  icb_copy_addr_gen #(
    .AW (AW),
    .DW (DW)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ptr_load),
    .adv_i  (ptr_adv),
    .src_i  (src_addr),
    .dst_i  (dst_addr),
    .src_o  (src_ptr),
    .dst_o  (dst_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      data_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_read_q  <= 1'b0;
      rsp_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len == '0) begin
              remain_q <= '0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              remain_q    <= len;
              cmd_valid_q <= 1'b1;
              cmd_read_q  <= 1'b1;
              state_q     <= ST_RD_CMD;
            end
          end
        end
        ST_RD_CMD: begin
          if (cmd_hs) begin
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
            state_q     <= ST_RD_RSP;
          end
        end
        ST_RD_RSP: begin
          if (rsp_hs) begin
            rsp_ready_q <= 1'b0;
            if (rsp_err_w) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              data_q      <= o_icb_rsp_rdata;
              cmd_valid_q <= 1'b1;
              cmd_read_q  <= 1'b0;
              state_q     <= ST_WR_CMD;
            end
          end
        end
        ST_WR_CMD: begin
          if (cmd_hs) begin
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
            state_q     <= ST_WR_RSP;
          end
        end
        ST_WR_RSP: begin
          if (rsp_hs) begin
            rsp_ready_q <= 1'b0;
            remain_q    <= remain_q - LEN_W'(1);
            if (rsp_err_w) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else if (remain_q == LEN_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              cmd_valid_q <= 1'b1;
              cmd_read_q  <= 1'b1;
              state_q     <= ST_RD_CMD;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          cmd_valid_q <= 1'b0;
          rsp_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign o_icb_cmd_valid = cmd_valid_q;
  assign o_icb_cmd_read  = cmd_read_q;
  assign o_icb_cmd_addr  = cmd_read_q ? src_ptr : dst_ptr;
  // Write data and mask are only driven for write commands; reads carry zeros
  assign o_icb_cmd_wdata = (cmd_valid_q & ~cmd_read_q) ? data_q : '0;
  assign o_icb_cmd_wmask = (cmd_valid_q & ~cmd_read_q) ? '1 : '0;
  assign o_icb_rsp_ready = rsp_ready_q;

endmodule

// File: tb/tb_icb_copy_master.sv
// tb_icb_copy_master
//   Scoreboard bench for icb_copy_master. Each job pushes its expected ICB
//   command stream (computed from src/dst/len with plain arithmetic) into a
//   queue; a monitor pops and compares at every command handshake. A
//   responder model answers commands, with optional stalls and delays.
//   Build option ICB_COPY_ERR_EN enables the response-error scenario.
`timescale 1ns/1ps
module tb_icb_copy_master;

  localparam int DW    = 32;
  localparam int AW    = 19;
  localparam int MW    = DW / 8;
  localparam int LEN_W = 16;
  localparam int BYTES = DW / 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    src_addr = '0;
  logic [AW-1:0]    dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err;
  logic             cmd_valid;
  logic             cmd_ready = 1'b1;
  logic             cmd_read;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_wdata;
  logic [MW-1:0]    cmd_wmask;
  logic             rsp_valid = 1'b0;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_rdata = '0;
`ifdef ICB_COPY_ERR_EN
  logic             rsp_err = 1'b0;
`endif

  always #5 clk = ~clk;

  icb_copy_master #(
    .DW    (DW),
    .AW    (AW),
    .MW    (MW),
    .LEN_W (LEN_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .len             (len),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .o_icb_cmd_valid (cmd_valid),
    .o_icb_cmd_ready (cmd_ready),
    .o_icb_cmd_read  (cmd_read),
    .o_icb_cmd_addr  (cmd_addr),
    .o_icb_cmd_wdata (cmd_wdata),
    .o_icb_cmd_wmask (cmd_wmask),
    .o_icb_rsp_valid (rsp_valid),
    .o_icb_rsp_ready (rsp_ready),
    .o_icb_rsp_rdata (rsp_rdata)
`ifdef ICB_COPY_ERR_EN
    ,
    .o_icb_rsp_err   (rsp_err)
`endif
  );

  typedef struct {
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  int done_cnt  = 0;
  int cmd_cnt   = 0;
  int stab_viol = 0;
  int rdy_viol  = 0;
  int unexp_cmd = 0;

  logic [31:0] seed = 32'h1234_5678;
  bit rand_mode  = 1'b0;
  int ready_low  = 0;
  int err_rd_idx = -1;
  int rd_rsp_idx = 0;

  // Memory contents seen by the responder: a per-job hash of the address
  function automatic logic [DW-1:0] datf(input logic [AW-1:0] a);
    return DW'(seed ^ (32'(a) * 32'h9E37_79B1));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: command-stream scoreboard plus protocol watchers
  initial begin : monitor
    bit            prev_pend;
    bit            outst;
    logic          prev_rd;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wd;
    cmd_t          e;
    prev_pend = 1'b0;
    outst     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 1'b0;
        outst     = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (rsp_ready && !outst) rdy_viol++;
        if (cmd_valid) begin
          if (prev_pend && (cmd_read !== prev_rd || cmd_addr !== prev_addr || cmd_wdata !== prev_wd))
            stab_viol++;
          if (cmd_ready) begin
            cmd_cnt++;
            outst     = 1'b1;
            prev_pend = 1'b0;
            if (exp_q.size() == 0) begin
              unexp_cmd++;
            end else begin
              e = exp_q.pop_front();
              chk("cmd_read", cmd_read, e.rd);
              chk("cmd_addr", cmd_addr, e.addr);
              chk(e.rd ? "rd_wdata" : "wr_wdata", cmd_wdata, e.rd ? {DW{1'b0}} : e.data);
              if (!e.rd) chk("wr_wmask", cmd_wmask, {MW{1'b1}});
            end
          end else begin
            prev_pend = 1'b1;
            prev_rd   = cmd_read;
            prev_addr = cmd_addr;
            prev_wd   = cmd_wdata;
          end
        end else if (prev_pend) begin
          stab_viol++;
          prev_pend = 1'b0;
        end
        if (rsp_valid && rsp_ready) outst = 1'b0;
      end
    end
  end

  // Responder: accepts commands and returns one response per command
  initial begin : responder
    bit            chs, rhs, pend, nerr, crd;
    int            dly;
    logic [AW-1:0] ca;
    logic [DW-1:0] nd;
    pend = 1'b0;
    dly  = 0;
    nerr = 1'b0;
    nd   = '0;
    forever begin
      @(negedge clk);
      chs = cmd_valid && cmd_ready;
      rhs = rsp_valid && rsp_ready;
      crd = cmd_read;
      ca  = cmd_addr;
      @(posedge clk);
      #1;
      if (rhs) begin
        rsp_valid = 1'b0;
`ifdef ICB_COPY_ERR_EN
        rsp_err = 1'b0;
`endif
      end
      if (chs) begin
        pend = 1'b1;
        dly  = rand_mode ? int'($urandom_range(0, 2)) : 0;
        if (crd) begin
          nd   = datf(ca);
          nerr = (rd_rsp_idx == err_rd_idx);
          rd_rsp_idx++;
        end else begin
          nd   = DW'($urandom);
          nerr = 1'b0;
        end
      end
      if (!rst_n) begin
        pend      = 1'b0;
        rsp_valid = 1'b0;
`ifdef ICB_COPY_ERR_EN
        rsp_err = 1'b0;
`endif
      end else if (pend && !rsp_valid) begin
        if (dly == 0) begin
          rsp_valid = 1'b1;
          rsp_rdata = nd;
`ifdef ICB_COPY_ERR_EN
          rsp_err = nerr;
`endif
          pend = 1'b0;
        end else begin
          dly--;
        end
      end
      if (ready_low > 0) begin
        cmd_ready = 1'b0;
        ready_low--;
      end else begin
        cmd_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Build the expected command stream for a job: word i reads src+i*BYTES and
  // writes what it read to dst+i*BYTES; an errored read ends the stream.
  function automatic int build_expect(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                      input int n, input int eidx);
    cmd_t c;
    int   cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      c.rd   = 1'b1;
      c.addr = src + AW'(i * BYTES);
      c.data = '0;
      exp_q.push_back(c);
      cnt++;
      if (i == eidx) break;
      c.rd   = 1'b0;
      c.addr = dst + AW'(i * BYTES);
      c.data = datf(src + AW'(i * BYTES));
      exp_q.push_back(c);
      cnt++;
    end
    return cnt;
  endfunction

  task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n,
                         input int exp_lat, input bit exp_err);
    int lat, d0, c0, ncmd;
    seed       = $urandom;
    rd_rsp_idx = 0;
    ncmd       = build_expect(src, dst, n, err_rd_idx);
    d0         = done_cnt;
    c0         = cmd_cnt;
    @(negedge clk);
    start    = 1'b1;
    src_addr = src;
    dst_addr = dst;
    len      = LEN_W'(n);
    @(posedge clk);
    #1;
    start    = 1'b0;
    src_addr = AW'($urandom);
    dst_addr = AW'($urandom);
    len      = LEN_W'($urandom);
    chk("busy_after_start", busy, 1'b1);
    chk("err_cleared_by_start", err, 1'b0);
    lat = 0;
    while (!done && lat < 2000) begin
      start = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
    if (exp_lat >= 0) chk("done_latency", lat, exp_lat);
    chk("err_at_done", err, exp_err);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("pending_cmds", exp_q.size(), 0);
    chk("cmd_count", cmd_cnt - c0, ncmd);
    chk("done_pulses", done_cnt - d0, 1);
    chk("cmd_stability", stab_viol, 0);
    chk("rsp_ready_idle", rdy_viol, 0);
    chk("unexpected_cmds", unexp_cmd, 0);
    chk("err_sticky", err, exp_err);
  endtask

  task automatic reset_mid_job();
    int t, d0, dummy;
    seed       = $urandom;
    rd_rsp_idx = 0;
    dummy      = build_expect(19'h300, 19'h400, 4, -1);
    @(negedge clk);
    start    = 1'b1;
    src_addr = 19'h300;
    dst_addr = 19'h400;
    len      = LEN_W'(4);
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(cmd_valid && !cmd_read) && t < 100);
    chk("reached_wr_cmd", cmd_valid && !cmd_read, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_rsp_ready", rsp_ready, 1'b0);
    chk("rst_cmd_addr", cmd_addr, '0);
    chk("rst_cmd_wdata", cmd_wdata, '0);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("idle_after_reset", busy, 1'b0);
    chk("no_rsp_ready_after_reset", rsp_ready, 1'b0);
    chk("no_cmd_after_reset", cmd_valid, 1'b0);
  endtask

  initial begin : main
    logic [AW-1:0] rs, rd;
    int            rn;
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_cmd_valid", cmd_valid, 1'b0);
    chk("reset_rsp_ready", rsp_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Four words, zero-wait responder: 4 cycles per word
    run_job(19'h100, 19'h200, 4, 16, 1'b0);
    // Zero-length job: straight to DONE, no ICB traffic
    run_job(19'h040, 19'h080, 0, 0, 1'b0);
    // First read command stalled by cmd_ready low
    ready_low = 6;
    run_job(19'h500, 19'h600, 2, -1, 1'b0);
    // Source and destination pointers wrapping past the top of the space
    run_job({AW{1'b1}} - AW'(3), 19'h700, 2, 8, 1'b0);
    run_job(19'h900, {AW{1'b1}} - AW'(7), 3, 12, 1'b0);

`ifdef ICB_COPY_ERR_EN
    err_rd_idx = 1;
    run_job(19'h800, 19'hA00, 4, -1, 1'b1);
    err_rd_idx = -1;
    run_job(19'hB00, 19'hC00, 2, 8, 1'b0);
`endif

    reset_mid_job();
    run_job(19'h1000, 19'h2000, 3, 12, 1'b0);

    rand_mode = 1'b1;
    repeat (10) begin
      rs = AW'($urandom) & ~AW'(BYTES - 1);
      rd = AW'($urandom) & ~AW'(BYTES - 1);
      rn = int'($urandom_range(0, 6));
      run_job(rs, rd, rn, -1, 1'b0);
    end
    rand_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
